// File: rtl/imm_rot_encoder_pkg.sv
// Shared definitions for the rotated-immediate encoder: widths, FSM states and
// a rotate-right helper used to cross-check encoded results.
package arm_pkg;

  localparam int DATA_W    = 32;
  localparam int ROT_STEPS = 16;
  localparam int ROT_W     = 4;
  localparam int IMM_W     = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    DONE   = 2'd2
  } imm_enc_state_t;

  // Rotate right by amt; amt == 0 returns d unchanged.
  function automatic logic [31:0] ror32(logic [31:0] d, logic [4:0] amt);
    logic [63:0] t;
    t = {d, d} >> amt;
    return t[31:0];
  endfunction

endpackage

// File: rtl/imm_rot_encoder_if.sv
// Request/result bundle of the rotated-immediate encoder.
interface imm_rot_encoder_if;
  import arm_pkg::*;

  logic              start;
  logic [DATA_W-1:0] value;
  logic              busy;
  logic              done;
  logic              valid;
  logic [ROT_W-1:0]  rot;
  logic [IMM_W-1:0]  imm8;
  logic [11:0]       operand2;

  modport master (
    output start, value,
    input  busy, done, valid, rot, imm8, operand2
  );

  modport slave (
    input  start, value,
    output busy, done, valid, rot, imm8, operand2
  );

endinterface

// File: rtl/imm_rot_encoder_chk.sv
// Property checker: a valid encoding must rotate back to the captured value.
module imm_rot_encoder_chk
  import arm_pkg::*;
(
  input logic              clk,
  input logic              reset_n,
  input logic              done,
  input logic              valid,
  input logic [ROT_W-1:0]  rot,
  input logic [IMM_W-1:0]  imm8,
  input logic [DATA_W-1:0] val
);

  a_roundtrip: assert property (@(posedge clk) disable iff (!reset_n)
    (done && valid) |-> (ror32({24'd0, imm8}, {rot, 1'b0}) == val));

  a_done_pulse: assert property (@(posedge clk) disable iff (!reset_n)
    done |=> !done);

endmodule

// File: rtl/imm_rot_encoder_rol32.sv
// Combinational 32-bit rotate-left.
module rol32 (
  input  logic [31:0] data,
  input  logic [4:0]  amt,
  output logic [31:0] result
);

  logic [63:0] dbl_s;

  // The upper half of the doubled word shifted left is the rotated word.
  assign dbl_s  = {data, data} << amt;
  assign result = dbl_s[63:32];

endmodule

// File: rtl/imm_rot_encoder.sv
// Sequential encoder for ARM rotated immediates: tries rot = 0..15, one per
// cycle, and reports the smallest rot whose rotated value fits in 8 bits.
module imm_rot_encoder
  import arm_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  imm_rot_encoder_if.slave   bus
);

  imm_enc_state_t    state_q, state_d;
  logic [DATA_W-1:0] val_q, val_d;
  logic [ROT_W-1:0]  cnt_q, cnt_d;
  logic [ROT_W-1:0]  rot_q, rot_d;
  logic [IMM_W-1:0]  imm8_q, imm8_d;
  logic              valid_q, valid_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] cand_s;
  logic              match_s;

  rol32 u_rol (
    .data   (val_q),
    .amt    ({cnt_q, 1'b0}),
    .result (cand_s)
  );

  assign match_s = (cand_s[DATA_W-1:IMM_W] == 24'd0);

  // Next-state and result update.
  always_comb begin
    state_d = state_q;
    val_d   = val_q;
    cnt_d   = cnt_q;
    rot_d   = rot_q;
    imm8_d  = imm8_q;
    valid_d = valid_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          val_d   = bus.value;
          cnt_d   = 4'd0;
          rot_d   = 4'd0;
          imm8_d  = 8'd0;
          valid_d = 1'b0;
          state_d = SEARCH;
        end else begin
          state_d = IDLE;
        end
      end
      SEARCH: begin
        if (match_s) begin
          rot_d   = cnt_q;
          imm8_d  = cand_s[IMM_W-1:0];
          valid_d = 1'b1;
          state_d = DONE;
        end else if (cnt_q == ROT_W'(ROT_STEPS - 1)) begin
          rot_d   = 4'd0;
          imm8_d  = 8'd0;
          valid_d = 1'b0;
          state_d = DONE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      val_q   <= 32'd0;
      cnt_q   <= 4'd0;
      rot_q   <= 4'd0;
      imm8_q  <= 8'd0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      val_q   <= val_d;
      cnt_q   <= cnt_d;
      rot_q   <= rot_d;
      imm8_q  <= imm8_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.valid    = valid_q;
  assign bus.rot      = rot_q;
  assign bus.imm8     = imm8_q;
  assign bus.operand2 = {rot_q, imm8_q};

  imm_rot_encoder_chk u_chk (
    .clk     (clk),
    .reset_n (reset_n),
    .done    (done_q),
    .valid   (valid_q),
    .rot     (rot_q),
    .imm8    (imm8_q),
    .val     (val_q)
  );

endmodule

// File: tb/tb_imm_rot_encoder.sv
// Scoreboard bench for imm_rot_encoder: randomized and directed constants checked
// against a bit-level model of the rotated-immediate encoding.
module tb_imm_rot_encoder;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  imm_rot_encoder_if bus ();

  imm_rot_encoder dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    logic       vld;
    logic [3:0] rot;
    logic [7:0] imm;
    int         lat;
    int         c0;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  logic done_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, req);
    end
  endtask

  // value bit i equals imm8 bit (i + 2r) mod 32; every set bit must land in the byte.
  function automatic exp_t model(logic [31:0] v);
    exp_t e;
    bit   found;
    bit   ok;
    logic [7:0] im;
    int   p;
    found = 1'b0;
    e.vld = 1'b0; e.rot = 4'd0; e.imm = 8'd0; e.lat = 17; e.c0 = 0;
    for (int r = 0; r < 16; r++) begin
      if (!found) begin
        ok = 1'b1;
        im = 8'd0;
        for (int i = 0; i < 32; i++) begin
          if (v[i]) begin
            p = (i + 2 * r) % 32;
            if (p >= 8) ok = 1'b0;
            else im[p] = 1'b1;
          end
        end
        if (ok) begin
          found = 1'b1;
          e.vld = 1'b1; e.rot = 4'(r); e.imm = im; e.lat = r + 2;
        end
      end
    end
    return e;
  endfunction

  function automatic logic [31:0] make_enc(logic [7:0] im, int r);
    logic [31:0] v;
    int p;
    v = 32'd0;
    for (int i = 0; i < 32; i++) begin
      p = (i + 2 * r) % 32;
      if (p < 8) v[i] = im[p];
    end
    return v;
  endfunction

  // Monitor: pops the scoreboard on every done pulse.
  always @(negedge clk) begin
    if (reset_n) begin
      if (done_prev) begin
        check("busy_after_done", {31'd0, bus.busy}, 32'd0);
        check("done_width", {31'd0, bus.done}, 32'd0);
      end
      if (bus.done) begin
        if (sbq.size() == 0) begin
          check("unexpected_done", 32'd1, 32'd0);
        end else begin
          mon_e = sbq.pop_front();
          check("valid", {31'd0, bus.valid}, {31'd0, mon_e.vld});
          check("rot", {28'd0, bus.rot}, {28'd0, mon_e.rot});
          check("imm8", {24'd0, bus.imm8}, {24'd0, mon_e.imm});
          check("operand2", {20'd0, bus.operand2}, {20'd0, mon_e.rot, mon_e.imm});
          check("latency", cyc - mon_e.c0, mon_e.lat);
          check("busy_at_done", {31'd0, bus.busy}, 32'd1);
        end
      end
      done_prev <= bus.done;
    end else begin
      done_prev <= 1'b0;
    end
  end

  task automatic wait_idle();
    int g;
    g = 0;
    while (bus.busy && g < 40) begin
      @(negedge clk);
      g++;
    end
    if (bus.busy) check("idle_timeout", 32'd1, 32'd0);
  endtask

  task automatic run(logic [31:0] v, bit spurious);
    exp_t e;
    wait_idle();
    e = model(v);
    e.c0 = cyc;
    sbq.push_back(e);
    bus.start = 1'b1;
    bus.value = v;
    @(negedge clk);
    bus.start = 1'b0;
    bus.value = $urandom;
    check("busy_after_start", {31'd0, bus.busy}, 32'd1);
    if (spurious) begin
      bus.start = 1'b1;
      bus.value = 32'h0000_0012;
      @(negedge clk);
      bus.start = 1'b0;
    end
    wait_idle();
    repeat ($urandom_range(0, 3)) @(negedge clk);
    check("held_valid", {31'd0, bus.valid}, {31'd0, e.vld});
    check("held_operand2", {20'd0, bus.operand2}, {20'd0, e.rot, e.imm});
  endtask

  logic [31:0] dir_vals [6] = '{32'h0000_00FF, 32'hFF00_0000, 32'hF000_000F,
                                32'h0000_03FC, 32'h0000_0101, 32'h0000_0000};

  initial begin
    bus.start = 1'b0;
    bus.value = 32'd0;
    #1 reset_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_valid", {31'd0, bus.valid}, 32'd0);
    check("rst_operand2", {20'd0, bus.operand2}, 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run(dir_vals[i], (i == 0) || (i == 3) || (i == 5));

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 2))
        0:       run(make_enc(8'($urandom), int'($urandom_range(0, 15))), 1'($urandom));
        1:       run({24'd0, 8'($urandom)} << $urandom_range(0, 24), 1'($urandom));
        default: run($urandom, 1'($urandom));
      endcase
    end

    // Reset in the middle of a long search: no done, outputs cleared at once.
    wait_idle();
    sbq.push_back(model(32'h0000_03FC));
    bus.start = 1'b1;
    bus.value = 32'h0000_03FC;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    reset_n = 1'b0;
    #1;
    check("midrst_busy", {31'd0, bus.busy}, 32'd0);
    check("midrst_done", {31'd0, bus.done}, 32'd0);
    check("midrst_valid", {31'd0, bus.valid}, 32'd0);
    check("midrst_rot", {28'd0, bus.rot}, 32'd0);
    check("midrst_imm8", {24'd0, bus.imm8}, 32'd0);
    check("midrst_operand2", {20'd0, bus.operand2}, 32'd0);
    sbq.delete(sbq.size() - 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("postrst_busy", {31'd0, bus.busy}, 32'd0);
    run(32'h0000_03FC, 1'b0);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/imm_rot_encoder.md
Name: imm_rot_encoder

Overview:
- Sequential encoder for ARM data-processing rotated immediates. The datapath shifter decodes an immediate of the form imm8 rotated right by 2*rot; this block does the inverse.
- Given a 32-bit constant, it searches rot = 0..15 one candidate per cycle. It returns the {rot, imm8} encoding with the smallest rot, or flags the constant as not encodable.
- It sits beside the shifter/extend logic and is used by the assembler-assist/test infrastructure and by the immediate-check path.

Parameters:
- DATA_W, 32, operand width; fixed at 32, and the search logic assumes 32.
- ROT_STEPS, 16, number of rotation candidates; rot field width is $clog2(ROT_STEPS) = 4.

Ports:
- clk  in  1  system clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- start  in  1  request pulse; sampled only while busy=0.
- value  in  32  constant to encode; captured on the accepted start edge.
- busy  out  1  high from the edge after start is accepted until done has been shown.
- done  out  1  one-cycle pulse: result is valid and stable.
- valid  out  1  1 = encodable; meaningful from done onward, held until next accepted start.
- rot  out  4  rotation field; effective right-rotate is 2*rot.
- imm8  out  8  immediate byte.
- operand2  out  12  {rot, imm8}, Instr[11:0] format.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - state=IDLE.
  - busy=0, done=0, valid=0, rot=0, imm8=0, operand2=0.
  - Internal value register and rotation counter cleared.
- States: IDLE, SEARCH, DONE.
- IDLE:
  - busy=0.
  - On a clock edge with start=1: capture value into val_q, clear cnt to 0, clear valid, go to SEARCH.
  - On that same edge, rot and imm8 are cleared to 0.
- SEARCH (busy=1), each cycle:
  - Candidate cand = ROL(val_q, 2*cnt), computed combinationally with a 32-bit rotate; shift amount 0 must yield val_q unchanged.
  - Match condition: cand[31:8]==0.
  - On match: register rot=cnt, imm8=cand[7:0], valid=1, go to DONE.
  - No match and cnt==15: rot=0, imm8=0, valid=0, go to DONE.
  - Otherwise cnt <= cnt+1; cnt never wraps.
- DONE:
  - busy=1, done=1 for exactly one cycle, then go to IDLE.
  - rot, imm8, operand2 and valid are held after DONE until the next accepted start.
- Latency:
  - A match at rot=k gives done high in the (k+2)th cycle after the start edge, i.e. k+1 full cycles of SEARCH plus the DONE cycle.
  - Worst case, or not encodable: done in cycle 17.
- Priority: the smallest rot always wins. Example: value 0 encodes as rot=0, imm8=0, valid=1.
- start while busy=1 (SEARCH or DONE) is ignored. value is not re-sampled, and no queueing occurs.
- start asserted on the same edge that IDLE is re-entered (i.e. during the DONE cycle) is ignored. A new request is accepted on the following edge if start is held.
- Correctness: for a valid result, ROR({24'b0, imm8}, 2*rot) == captured value. Check with an assertion.
- Reset asserted mid-SEARCH or in DONE: immediate return to IDLE with all outputs at reset values, and no done pulse.
- operand2 is continuously {rot, imm8}. There are no combinational paths from inputs to outputs.

Decomposition:
- Shared package arm_pkg holds:
  - enum imm_enc_state_t {IDLE, SEARCH, DONE};
  - constants DATA_W=32, ROT_W=4, IMM_W=8.
- Sub-module rol32 (combinational): inputs data[31:0] and amt[4:0], output = rotate-left. Instantiated once with amt={cnt,1'b0}.

Test Plan:
- value=0x000000FF, start pulse → done 2nd cycle after start edge; valid=1, rot=0, imm8=0xFF, operand2=0x0FF.
- value=0xFF000000 → done in cycle 6; rot=4, imm8=0xFF, operand2=0x4FF.
- value=0xF000000F → done in cycle 4; rot=2, imm8=0xFF. value=0x000003FC → done in cycle 17; rot=15, imm8=0xFF, operand2=0xFFF.
- value=0x00000101 → done in cycle 17; valid=0, rot=0, imm8=0; busy drops the cycle after done.
- Second start with value=0x12 during SEARCH → ignored, first result unchanged. value=0 → rot=0, imm8=0, valid=1 with 1-cycle search.
- reset_n low for 1 cycle mid-SEARCH of 0x000003FC → outputs zero immediately, no done. A fresh start then completes normally.
